// File: rtl/lb_initiator_pkg.sv
// Shared types and constants for the ghostbus local-bus initiator.
package lb_initiator_pkg;

    // Width of the read-latency counter; bounds the legal READ_DELAY range.
    localparam int unsigned LB_CNT_W = 4;

    // READ_DELAY legality limits.
    localparam int unsigned LB_READ_DELAY_MIN = 1;
    localparam int unsigned LB_READ_DELAY_MAX = (1 << LB_CNT_W) - 1;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        WAIT,
        RESP
    } lb_state_t;

    function automatic bit lb_read_delay_ok(input int unsigned d);
        return (d >= LB_READ_DELAY_MIN) && (d <= LB_READ_DELAY_MAX);
    endfunction

endpackage

// File: rtl/lb_initiator_if.sv
// Command/response streams plus ghostbus local-bus signals of one initiator.
interface lb_initiator_if #(
    parameter int unsigned AW = 24,
    parameter int unsigned DW = 32
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;

    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;

    logic [AW-1:0] lb_addr;
    logic [DW-1:0] lb_wdata;
    logic          lb_wstb;
    logic          lb_rstb;
    logic [DW-1:0] lb_rdata;

    // The initiator itself.
    modport master (
        input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready, lb_rdata,
        output cmd_ready, rsp_valid, rsp_data, lb_addr, lb_wdata, lb_wstb, lb_rstb
    );

    // Host transport plus bus responders surrounding the initiator.
    modport slave (
        output cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready, lb_rdata,
        input  cmd_ready, rsp_valid, rsp_data, lb_addr, lb_wdata, lb_wstb, lb_rstb
    );

endinterface

// File: rtl/lb_rd_delay.sv
// Loadable down-counter with a zero flag; times the read latency of a ghostbus master.
module lb_rd_delay
    import lb_initiator_pkg::*;
#(
    parameter int unsigned W = LB_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         done
);

    logic [W-1:0] cnt;

    // Load has priority over decrement; reset parks the counter at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec) begin
            cnt <= cnt - W'(1);
        end
    end

    assign done = (cnt == '0);

    // Callers only decrement while done is low, so a wrap past zero means a broken caller.
    a_no_underflow: assert property (@(posedge clk) disable iff (rst) dec |-> !done);

endmodule

// File: rtl/lb_initiator.sv
// Single-outstanding ghostbus initiator: stream commands in, one-cycle bus strobes out,
// read data returned on a response stream after a fixed READ_DELAY.
module lb_initiator
    import lb_initiator_pkg::*;
#(
    parameter int unsigned AW         = 24,
    parameter int unsigned DW         = 32,
    parameter int unsigned READ_DELAY = 2
) (
    input  logic           clk,
    input  logic           rst,
    lb_initiator_if.master bus,
    output logic           busy
);

    if (!lb_read_delay_ok(READ_DELAY)) begin : g_bad_read_delay
        $error("lb_initiator: READ_DELAY=%0d outside %0d..%0d",
               READ_DELAY, LB_READ_DELAY_MIN, LB_READ_DELAY_MAX);
    end

    localparam logic [LB_CNT_W-1:0] DELAY_LOAD = LB_CNT_W'(READ_DELAY - 1);

    lb_state_t     state;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          wstb_q;
    logic          rstb_q;
    logic          rsp_valid_q;
    logic [DW-1:0] rsp_data_q;
    logic          cnt_done;

    lb_rd_delay #(
        .W (LB_CNT_W)
    ) u_rd_delay (
        .clk      (clk),
        .rst      (rst),
        .load     (state == READ),
        .load_val (DELAY_LOAD),
        .dec      ((state == WAIT) && !cnt_done),
        .done     (cnt_done)
    );

    // Transaction FSM; strobes are raised on entry to WRITE/READ so they stay registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstb_q      <= 1'b0;
            rstb_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            wstb_q <= 1'b0;
            rstb_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        addr_q <= bus.cmd_addr;
                        if (bus.cmd_we) begin
                            wdata_q <= bus.cmd_wdata;
                            wstb_q  <= 1'b1;
                            state   <= WRITE;
                        end else begin
                            rstb_q  <= 1'b1;
                            state   <= READ;
                        end
                    end
                end
                WRITE: state <= IDLE;
                READ:  state <= WAIT;
                WAIT: begin
                    if (cnt_done) begin
                        rsp_data_q  <= bus.lb_rdata;
                        rsp_valid_q <= 1'b1;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = (state == IDLE) && !rst;
    assign busy          = (state != IDLE) && !rst;
    assign bus.lb_addr   = addr_q;
    assign bus.lb_wdata  = wdata_q;
    assign bus.lb_wstb   = wstb_q;
    assign bus.lb_rstb   = rstb_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_lb_initiator.sv
// Directed bench for lb_initiator: three instances (READ_DELAY 2, 1, 15), each with a
// small RAM bus model that only presents valid data in the exact sampling cycle.
module tb_lb_initiator;

    localparam int unsigned NI = 3;
    localparam int unsigned RDS [NI] = '{2, 1, 15};

    typedef struct {
        int unsigned d;
        logic        we;
        logic [23:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        cmd_valid [NI];
    logic        cmd_we    [NI];
    logic [23:0] cmd_addr  [NI];
    logic [31:0] cmd_wdata [NI];
    logic        rsp_ready [NI];
    logic        cmd_ready [NI];
    logic        rsp_valid [NI];
    logic [31:0] rsp_data  [NI];
    logic [23:0] lb_addr   [NI];
    logic [31:0] lb_wdata  [NI];
    logic        lb_wstb   [NI];
    logic        lb_rstb   [NI];
    logic        busy      [NI];

    logic [31:0] last_wdata [NI];
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int unsigned RD = RDS[g];

        lb_initiator_if #(.AW(24), .DW(32)) bus ();

        lb_initiator #(
            .AW         (24),
            .DW         (32),
            .READ_DELAY (RD)
        ) dut (
            .clk  (clk),
            .rst  (rst),
            .bus  (bus),
            .busy (busy[g])
        );

        assign bus.cmd_valid = cmd_valid[g];
        assign bus.cmd_we    = cmd_we[g];
        assign bus.cmd_addr  = cmd_addr[g];
        assign bus.cmd_wdata = cmd_wdata[g];
        assign bus.rsp_ready = rsp_ready[g];
        assign cmd_ready[g]  = bus.cmd_ready;
        assign rsp_valid[g]  = bus.rsp_valid;
        assign rsp_data[g]   = bus.rsp_data;
        assign lb_addr[g]    = bus.lb_addr;
        assign lb_wdata[g]   = bus.lb_wdata;
        assign lb_wstb[g]    = bus.lb_wstb;
        assign lb_rstb[g]    = bus.lb_rstb;

        // RAM responder: data is valid only in cycle rstb+RD, junk otherwise.
        logic [31:0] mem [256];
        logic [7:0]  ra;
        logic [15:0] pipe;

        always @(posedge clk) begin
            if (rst) begin
                pipe <= '0;
                ra   <= '0;
                for (int i = 0; i < 256; i++)
                    mem[i] <= (i == 1) ? 32'hFACEF00D : (32'hC0DE0000 | 32'(i));
            end else begin
                if (bus.lb_wstb) mem[bus.lb_addr[7:0]] <= bus.lb_wdata;
                if (bus.lb_rstb) ra <= bus.lb_addr[7:0];
                pipe <= {pipe[14:0], bus.lb_rstb};
            end
        end

        assign bus.lb_rdata = pipe[RD-1] ? mem[ra] : 32'hBAD0BAD0;
    end

    task automatic chk(input int unsigned d, input string nm,
                       input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL d%0d %s: got 0x%0h want 0x%0h", d, nm, act, exp);
        end
    endtask

    task automatic drive(input int unsigned d, input logic we,
                         input logic [23:0] a, input logic [31:0] w);
        cmd_valid[d] = 1'b1;
        cmd_we[d]    = we;
        cmd_addr[d]  = a;
        cmd_wdata[d] = w;
    endtask

    // One isolated transaction with full cycle-by-cycle timing checks.
    task automatic run_vec(input vec_t v);
        int unsigned d;
        int unsigned rd;
        d  = v.d;
        rd = RDS[v.d];
        chk(d, "idle_ready", 32'(cmd_ready[d]), 32'd1);
        drive(d, v.we, v.addr, v.wdata);
        @(negedge clk);
        cmd_valid[d] = 1'b0;
        chk(d, "lb_addr", 32'(lb_addr[d]), 32'(v.addr));
        chk(d, "busy", 32'(busy[d]), 32'd1);
        if (v.we) begin
            chk(d, "wr_wstb", 32'(lb_wstb[d]), 32'd1);
            chk(d, "wr_rstb", 32'(lb_rstb[d]), 32'd0);
            chk(d, "wr_wdata", lb_wdata[d], v.wdata);
            chk(d, "wr_ready_t1", 32'(cmd_ready[d]), 32'd0);
            chk(d, "wr_rsp_valid", 32'(rsp_valid[d]), 32'd0);
            last_wdata[d] = v.wdata;
            @(negedge clk);
            chk(d, "wr_wstb_t2", 32'(lb_wstb[d]), 32'd0);
            chk(d, "wr_ready_t2", 32'(cmd_ready[d]), 32'd1);
            chk(d, "wr_rsp_valid_t2", 32'(rsp_valid[d]), 32'd0);
        end else begin
            chk(d, "rd_rstb", 32'(lb_rstb[d]), 32'd1);
            chk(d, "rd_wstb", 32'(lb_wstb[d]), 32'd0);
            chk(d, "rd_wdata_kept", lb_wdata[d], last_wdata[d]);
            for (int unsigned k = 2; k <= rd + 1; k++) begin
                @(negedge clk);
                chk(d, "rd_early_valid", 32'(rsp_valid[d]), 32'd0);
                chk(d, "rd_rstb_once", 32'(lb_rstb[d]), 32'd0);
            end
            @(negedge clk);
            chk(d, "rd_rsp_valid", 32'(rsp_valid[d]), 32'd1);
            chk(d, "rd_rsp_data", rsp_data[d], v.exp);
            chk(d, "rd_ready_resp", 32'(cmd_ready[d]), 32'd0);
            @(negedge clk);
            chk(d, "rd_rsp_cleared", 32'(rsp_valid[d]), 32'd0);
            chk(d, "rd_ready_back", 32'(cmd_ready[d]), 32'd1);
        end
    endtask

    // Response stall on instance 0 with a write waiting on cmd_valid.
    task automatic stall_test();
        int unsigned rd;
        rd = RDS[0];
        drive(0, 1'b0, 24'h000001, 32'h0);
        rsp_ready[0] = 1'b0;
        @(negedge clk);
        chk(0, "st_rstb", 32'(lb_rstb[0]), 32'd1);
        drive(0, 1'b1, 24'h000030, 32'h13572468);
        for (int unsigned k = 2; k <= rd + 1; k++) @(negedge clk);
        for (int unsigned k = 0; k < 5; k++) begin
            @(negedge clk);
            chk(0, "st_valid", 32'(rsp_valid[0]), 32'd1);
            chk(0, "st_data", rsp_data[0], 32'hFACEF00D);
            chk(0, "st_ready_blocked", 32'(cmd_ready[0]), 32'd0);
            chk(0, "st_no_wstb", 32'(lb_wstb[0]), 32'd0);
        end
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        chk(0, "st_valid_cleared", 32'(rsp_valid[0]), 32'd0);
        chk(0, "st_ready_resume", 32'(cmd_ready[0]), 32'd1);
        @(negedge clk);
        cmd_valid[0] = 1'b0;
        chk(0, "st_wr_wstb", 32'(lb_wstb[0]), 32'd1);
        chk(0, "st_wr_addr", 32'(lb_addr[0]), 32'h30);
        chk(0, "st_wr_data", lb_wdata[0], 32'h13572468);
        last_wdata[0] = 32'h13572468;
        @(negedge clk);
    endtask

    // Eight back-to-back commands with cmd_valid held high: W/R pairs on 0x40..0x43.
    task automatic stream_test();
        logic [31:0] exp_q [$];
        logic [31:0] got;
        int unsigned k;
        int unsigned nrsp;
        int unsigned cyc;
        logic        acc;
        k    = 0;
        nrsp = 0;
        cyc  = 0;
        acc  = 1'b0;
        drive(0, 1'b1, 24'h40, 32'h5A5A0000);
        while ((k < 8 || nrsp < 4) && cyc < 300) begin
            @(negedge clk);
            cyc++;
            chk(0, "sm_no_overlap", 32'(lb_wstb[0] & lb_rstb[0]), 32'd0);
            if (rsp_valid[0]) begin
                nrsp++;
                if (exp_q.size() == 0) begin
                    chk(0, "sm_unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    got = exp_q.pop_front();
                    chk(0, "sm_rd_data", rsp_data[0], got);
                end
            end
            if (acc) begin
                acc = 1'b0;
                k++;
                if (k < 8)
                    drive(0, (k % 2) == 0, 24'h40 + 24'(k / 2), 32'h5A5A0000 + 32'(k & ~32'd1));
                else
                    cmd_valid[0] = 1'b0;
            end
            if (k < 8 && cmd_ready[0]) begin
                acc = 1'b1;
                if (!cmd_we[0]) exp_q.push_back(32'h5A5A0000 + 32'(k - 1));
            end
        end
        chk(0, "sm_cmds_done", k, 32'd8);
        chk(0, "sm_rsp_count", nrsp, 32'd4);
        last_wdata[0] = 32'h5A5A0006;
    endtask

    // Reset asserted while a read sits in WAIT: everything returns to reset values, no response.
    task automatic reset_test();
        drive(0, 1'b0, 24'h000001, 32'h0);
        @(negedge clk);
        cmd_valid[0] = 1'b0;
        @(negedge clk);
        chk(0, "rs_busy_in_wait", 32'(busy[0]), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk(0, "rs_cmd_ready", 32'(cmd_ready[0]), 32'd0);
        chk(0, "rs_busy", 32'(busy[0]), 32'd0);
        chk(0, "rs_lb_addr", 32'(lb_addr[0]), 32'd0);
        chk(0, "rs_lb_wdata", lb_wdata[0], 32'd0);
        chk(0, "rs_wstb", 32'(lb_wstb[0]), 32'd0);
        chk(0, "rs_rstb", 32'(lb_rstb[0]), 32'd0);
        chk(0, "rs_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        chk(0, "rs_rsp_data", rsp_data[0], 32'd0);
        rst = 1'b0;
        for (int unsigned i = 0; i < NI; i++) last_wdata[i] = 32'd0;
        for (int unsigned k = 0; k < 6; k++) begin
            @(negedge clk);
            chk(0, "rs_no_rsp", 32'(rsp_valid[0]), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [11];
        vecs = '{
            '{0, 1'b1, 24'h000010, 32'hDEADBEEF, 32'h0},
            '{0, 1'b0, 24'h000001, 32'h0,        32'hFACEF00D},
            '{0, 1'b1, 24'h000020, 32'h12345678, 32'h0},
            '{0, 1'b0, 24'h000020, 32'h0,        32'h12345678},
            '{0, 1'b0, 24'h000010, 32'h0,        32'hDEADBEEF},
            '{1, 1'b0, 24'h000001, 32'h0,        32'hFACEF00D},
            '{1, 1'b1, 24'h0000FF, 32'hA5A5A5A5, 32'h0},
            '{1, 1'b0, 24'h0000FF, 32'h0,        32'hA5A5A5A5},
            '{2, 1'b0, 24'h000001, 32'h0,        32'hFACEF00D},
            '{2, 1'b1, 24'h000003, 32'h0BADCAFE, 32'h0},
            '{2, 1'b0, 24'h000003, 32'h0,        32'h0BADCAFE}
        };
        for (int unsigned i = 0; i < NI; i++) begin
            cmd_valid[i]  = 1'b0;
            cmd_we[i]     = 1'b0;
            cmd_addr[i]   = '0;
            cmd_wdata[i]  = '0;
            rsp_ready[i]  = 1'b1;
            last_wdata[i] = '0;
        end

        @(negedge clk);
        for (int unsigned i = 0; i < NI; i++) begin
            chk(i, "rst_cmd_ready", 32'(cmd_ready[i]), 32'd0);
            chk(i, "rst_busy", 32'(busy[i]), 32'd0);
            chk(i, "rst_lb_addr", 32'(lb_addr[i]), 32'd0);
            chk(i, "rst_lb_wdata", lb_wdata[i], 32'd0);
            chk(i, "rst_strobes", 32'({lb_wstb[i], lb_rstb[i]}), 32'd0);
            chk(i, "rst_rsp", 32'(rsp_valid[i]), 32'd0);
            chk(i, "rst_rsp_data", rsp_data[i], 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int unsigned i = 0; i < 11; i++) run_vec(vecs[i]);

        stall_test();
        stream_test();
        @(negedge clk);
        reset_test();
        run_vec(vecs[1]);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
